// File: rtl/dual_path_fetch_ctrl_pkg.sv
// rtl/dual_path_fetch_ctrl_pkg.sv - shared fetch PC width, increment, reset PC, fork state and helpers
package dual_path_fetch_ctrl_pkg;

  localparam int PC_W      = 10;
  localparam int FETCH_INC = 2;
  localparam int RESET_PC  = 0;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic {
    ST_UNIFIED = 1'b0,
    ST_FORKED  = 1'b1
  } dpf_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpf_pc_reg.sv
// rtl/dpf_pc_reg.sv - one pipe's fetch PC register: load beats hold, hold beats increment
module dpf_pc_reg #(
  parameter int W       = 10,
  parameter int INC     = 2,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_pc,
  input  logic         hold,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= W'(RST_VAL);
    else if (load)
      pc <= load_pc;
    else if (!hold)
      pc <= pc + W'(INC);
  end

endmodule

// File: rtl/dual_path_fetch_ctrl.sv
// rtl/dual_path_fetch_ctrl.sv - taken/not-taken fetch PC generator with fork and EX redirect handling
// Optional perf counters (fork_cnt, t_win_cnt, n_win_cnt) are built when DPF_PERF_CNT_EN is defined.
module dual_path_fetch_ctrl
  import dual_path_fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_id,
  input  logic [PC_W-1:0] bta_id,
  input  logic [PC_W-1:0] fall_id,
  input  logic            correct_en_t,
  input  logic [PC_W-1:0] correction_t,
  input  logic            correct_en_n,
  input  logic [PC_W-1:0] correction_n,
  output logic [PC_W-1:0] pc_t,
  output logic [PC_W-1:0] pc_n,
  output logic            forked,
  output logic            live_n,
  output logic            corr_err
`ifdef DPF_PERF_CNT_EN
  ,
  output logic [15:0]     fork_cnt,
  output logic [15:0]     t_win_cnt,
  output logic [15:0]     n_win_cnt
`endif
);

  dpf_state_e      state;
  logic            any_corr;
  logic            take_t_corr;
  logic            do_fork;
  logic            load_t;
  logic            load_n;
  logic [PC_W-1:0] load_pc_t;
  logic [PC_W-1:0] load_pc_n;

  // n redirect wins when both arrive, so the t redirect only counts when alone
  assign any_corr    = correct_en_t | correct_en_n;
  assign take_t_corr = correct_en_t & ~correct_en_n;
  assign do_fork     = (state == ST_UNIFIED) & br_id & ~stall & ~any_corr;

  assign load_t    = take_t_corr | do_fork;
  assign load_pc_t = do_fork ? bta_id : correction_t;
  assign load_n    = correct_en_n | do_fork;
  assign load_pc_n = correct_en_n ? correction_n : fall_id;

  dpf_pc_reg #(.W(PC_W), .INC(FETCH_INC), .RST_VAL(RESET_PC)) u_pc_t (
    .clk     (clk),
    .rst     (rst),
    .load    (load_t),
    .load_pc (load_pc_t),
    .hold    (stall),
    .pc      (pc_t)
  );

  dpf_pc_reg #(.W(PC_W), .INC(FETCH_INC), .RST_VAL(RESET_PC)) u_pc_n (
    .clk     (clk),
    .rst     (rst),
    .load    (load_n),
    .load_pc (load_pc_n),
    .hold    (stall),
    .pc      (pc_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_UNIFIED;
      forked   <= 1'b0;
      live_n   <= 1'b0;
      corr_err <= 1'b0;
    end else begin
      corr_err <= correct_en_t & correct_en_n;
      if (correct_en_n) begin
        state  <= ST_UNIFIED;
        forked <= 1'b0;
        live_n <= 1'b0;
      end else if (correct_en_t) begin
        state  <= ST_UNIFIED;
        forked <= 1'b0;
        live_n <= 1'b1;
      end else if (do_fork) begin
        state  <= ST_FORKED;
        forked <= 1'b1;
      end
    end
  end

`ifdef DPF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fork_cnt  <= 16'd0;
      t_win_cnt <= 16'd0;
      n_win_cnt <= 16'd0;
    end else begin
      if (do_fork)      fork_cnt  <= sat_inc16(fork_cnt);
      if (correct_en_n) t_win_cnt <= sat_inc16(t_win_cnt);
      if (take_t_corr)  n_win_cnt <= sat_inc16(n_win_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dual_path_fetch_ctrl.sv
// tb/tb_dual_path_fetch_ctrl.sv - directed and random checks of dual_path_fetch_ctrl against a path model
// Counter checks are compiled in only when DPF_PERF_CNT_EN is defined.
module tb_dual_path_fetch_ctrl;
  import dual_path_fetch_ctrl_pkg::*;

  localparam int MOD = 1 << PC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, br_id = 1'b0, correct_en_t = 1'b0, correct_en_n = 1'b0;
  pc_t  bta_id = '0, fall_id = '0, correction_t = '0, correction_n = '0;
  pc_t  pc_t_o, pc_n_o;
  logic forked, live_n, corr_err;
`ifdef DPF_PERF_CNT_EN
  logic [15:0] fork_cnt, t_win_cnt, n_win_cnt;
`endif

  dual_path_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_id        (br_id),
    .bta_id       (bta_id),
    .fall_id      (fall_id),
    .correct_en_t (correct_en_t),
    .correction_t (correction_t),
    .correct_en_n (correct_en_n),
    .correction_n (correction_n),
    .pc_t         (pc_t_o),
    .pc_n         (pc_n_o),
    .forked       (forked),
    .live_n       (live_n),
    .corr_err     (corr_err)
`ifdef DPF_PERF_CNT_EN
    ,
    .fork_cnt     (fork_cnt),
    .t_win_cnt    (t_win_cnt),
    .n_win_cnt    (n_win_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: two path addresses plus a "paths diverge" flag
  int m_t, m_n, m_fc, m_tc, m_nc;
  bit m_fk, m_live, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = RESET_PC; m_n = RESET_PC;
    m_fk = 0; m_live = 0; m_err = 0;
    m_fc = 0; m_tc = 0; m_nc = 0;
  endtask

  task automatic model_update();
    int adv;
    adv = stall ? 0 : FETCH_INC;
    m_err = correct_en_t && correct_en_n;
    if (correct_en_n) begin
      m_n = correction_n; m_t = (m_t + adv) % MOD;
      m_fk = 0; m_live = 0;
      if (m_tc < 65535) m_tc++;
    end else if (correct_en_t) begin
      m_t = correction_t; m_n = (m_n + adv) % MOD;
      m_fk = 0; m_live = 1;
      if (m_nc < 65535) m_nc++;
    end else if (!stall && br_id && !m_fk) begin
      m_t = bta_id; m_n = fall_id; m_fk = 1;
      if (m_fc < 65535) m_fc++;
    end else begin
      m_t = (m_t + adv) % MOD; m_n = (m_n + adv) % MOD;
    end
  endtask

  task automatic compare_all();
    check("pc_t", 32'(pc_t_o), 32'(m_t));
    check("pc_n", 32'(pc_n_o), 32'(m_n));
    check("forked", 32'(forked), 32'(m_fk));
    check("live_n", 32'(live_n), 32'(m_live));
    check("corr_err", 32'(corr_err), 32'(m_err));
`ifdef DPF_PERF_CNT_EN
    check("fork_cnt", 32'(fork_cnt), 32'(m_fc));
    check("t_win_cnt", 32'(t_win_cnt), 32'(m_tc));
    check("n_win_cnt", 32'(n_win_cnt), 32'(m_nc));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle();
    stall = 0; br_id = 0; correct_en_t = 0; correct_en_n = 0;
  endtask

  task automatic cyc(input bit s, input bit b, input int bta, input int fall,
                     input bit ct, input int cpt, input bit cn, input int cpn);
    stall = s; br_id = b; bta_id = pc_t'(bta); fall_id = pc_t'(fall);
    correct_en_t = ct; correction_t = pc_t'(cpt);
    correct_en_n = cn; correction_n = pc_t'(cpn);
    step();
    idle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_t", 32'(pc_t_o), 32'(RESET_PC));
    check("rst_pc_n", 32'(pc_n_o), 32'(RESET_PC));
    check("rst_forked", 32'(forked), 0);
    check("rst_corr_err", 32'(corr_err), 0);
    @(negedge clk); rst = 0;

    // fork from pc 0x010
    repeat (8) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("pre_fork_pc", 32'(pc_t_o), 32'h010);
    cyc(0, 1, 'h080, 'h012, 0, 0, 0, 0);
    check("fork_pc_t", 32'(pc_t_o), 32'h080);
    check("fork_pc_n", 32'(pc_n_o), 32'h012);
    check("fork_flag", 32'(forked), 1);

    // taken resolution, then a not-taken one after a new fork
    cyc(0, 0, 0, 0, 0, 0, 1, 'h084);
    check("cn_pc_n", 32'(pc_n_o), 32'h084);
    check("cn_pc_t", 32'(pc_t_o), 32'h082);
    check("cn_forked", 32'(forked), 0);
    check("cn_live", 32'(live_n), 0);
    cyc(0, 1, 'h100, 'h086, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h014, 0, 0);
    check("ct_pc_t", 32'(pc_t_o), 32'h014);
    check("ct_pc_n", 32'(pc_n_o), 32'h088);
    check("ct_live", 32'(live_n), 1);

    // wrap, then stall in FORKED
    cyc(0, 0, 0, 0, 1, 'h3FE, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc_t", 32'(pc_t_o), 32'h000);
    cyc(0, 1, 'h200, 'h090, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("stall_pc_t", 32'(pc_t_o), 32'h200);
      check("stall_pc_n", 32'(pc_n_o), 32'h090);
      check("stall_forked", 32'(forked), 1);
    end

    // correction beats fork; stall suppresses fork; double correction
    cyc(0, 0, 0, 0, 0, 0, 1, 'h040);
    cyc(0, 1, 'h300, 'h042, 1, 'h020, 0, 0);
    check("corr_vs_fork_pc_t", 32'(pc_t_o), 32'h020);
    check("corr_vs_fork_forked", 32'(forked), 0);
    cyc(1, 1, 'h300, 'h022, 0, 0, 0, 0);
    check("stall_br_forked", 32'(forked), 0);
    check("stall_br_pc_t", 32'(pc_t_o), 32'h020);
    cyc(0, 0, 0, 0, 1, 'h060, 1, 'h050);
    check("both_pc_n", 32'(pc_n_o), 32'h050);
    check("both_pc_t", 32'(pc_t_o), 32'h022);
    check("both_err", 32'(corr_err), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("both_err_drop", 32'(corr_err), 0);

    // asynchronous reset mid-cycle
    cyc(0, 0, 0, 0, 1, 'h1A4, 0, 0);
    check("pre_rst_pc_t", 32'(pc_t_o), 32'h1A4);
    #2 rst = 1;
    #1;
    check("arst_pc_t", 32'(pc_t_o), 0);
    check("arst_pc_n", 32'(pc_n_o), 0);
    check("arst_forked", 32'(forked), 0);
    check("arst_live", 32'(live_n), 0);
    model_reset();
    @(negedge clk); rst = 0;

    // 3 forks, 2 taken and 1 not-taken resolutions
    cyc(0, 1, 'h100, 'h002, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 'h104);
    cyc(0, 1, 'h200, 'h106, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 'h204);
    cyc(0, 1, 'h300, 'h206, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h208, 0, 0);
`ifdef DPF_PERF_CNT_EN
    check("perf_fork", 32'(fork_cnt), 3);
    check("perf_t_win", 32'(t_win_cnt), 2);
    check("perf_n_win", 32'(n_win_cnt), 1);
`endif

    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
          $urandom_range(0, 7) == 0, $urandom_range(0, MOD - 1),
          $urandom_range(0, 7) == 0, $urandom_range(0, MOD - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
